// File: rtl/fp_subtractor_seq_pkg.sv
// Shared binary32 helpers for the sequential subtractor: field/class types,
// well-known constants, the operand classifier and the FSM state encoding.
package fp_subtractor_seq_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp_fields_t;

  typedef enum logic [2:0] {
    ZERO,
    NORMAL,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADDSUB,
    S_NORM,
    S_ROUND,
    S_DONE
  } fsm_state_e;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam int          FP_BIAS    = 127;

  // Exponent-0 operands classify as ZERO so denormals are flushed.
  function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                            input logic frac_zero, input logic frac_msb);
    fp_class_e cls;
    if (exp_zero) begin
      cls = ZERO;
    end else if (!exp_ones) begin
      cls = NORMAL;
    end else if (frac_zero) begin
      cls = INF;
    end else if (frac_msb) begin
      cls = QNAN;
    end else begin
      cls = SNAN;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational right shift of the {hidden,frac,G,R,S} field; every bit shifted
// out is ORed into the sticky LSB so rounding still sees it.
module fp_align_shifter #(
  parameter int FW = 27,
  parameter int SW = 8
) (
  input  logic [FW-1:0] i_data,
  input  logic [SW-1:0] i_shamt,
  output logic [FW-1:0] o_data
);

  logic          w_lost;
  logic [FW-1:0] w_shr;

  // Collect the bits that fall off the bottom and shift the rest down.
  always_comb begin
    w_lost = 1'b0;
    for (int i = 0; i < FW; i++) begin
      if (i < int'(i_shamt)) begin
        w_lost = w_lost | i_data[i];
      end else begin
        w_lost = w_lost;
      end
    end
    w_shr = i_data >> i_shamt;
  end

  assign o_data = {w_shr[FW-1:1], w_shr[0] | w_lost};

endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 subtractor (result = op_a - op_b) on a valid/ready stream.
// op_b is negated at capture; the FSM then aligns, adds, normalises and rounds.
module fp_subtractor_seq
  import fp_subtractor_seq_pkg::*;
#(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0]   op_a,
  input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0]   op_b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_SIZE+MANTISSA_SIZE:0]   result,
  output logic [3:0]                             flags
);

  localparam int M  = MANTISSA_SIZE;
  localparam int E  = EXPONENT_SIZE;
  localparam int W  = 1 + E + M;
  localparam int FW = M + 4;
  localparam int XW = E + 2;

  localparam logic [W-1:0]  QNAN_C    = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
  localparam logic [XW-1:0] EXP_MAX_C = {2'b00, {E{1'b1}}};
  localparam logic [XW-1:0] EXP_ONE_C = {{(XW-1){1'b0}}, 1'b1};

  fsm_state_e    r_state;
  logic          r_in_ready, r_out_valid;
  logic [W-1:0]  r_result;
  logic [3:0]    r_flags;
  logic          r_a_sign, r_b_sign;
  logic [E-1:0]  r_a_exp, r_b_exp;
  logic [M-1:0]  r_a_frac, r_b_frac;
  logic          r_sign, r_sub;
  logic [XW-1:0] r_exp;
  logic [FW-1:0] r_mant_a, r_mant_b;
  logic [FW:0]   r_mant;

  logic          w_a_sign, w_b_sign;
  logic [E-1:0]  w_a_exp, w_b_exp;
  logic [M-1:0]  w_a_frac, w_b_frac;
  fp_class_e     w_a_cls, w_b_cls;
  logic          w_a_nan, w_b_nan;
  logic          w_special, w_spec_invalid;
  logic [W-1:0]  w_spec_result;

  assign w_a_sign = op_a[W-1];
  assign w_a_exp  = op_a[W-2:M];
  assign w_a_frac = op_a[M-1:0];
  assign w_b_sign = ~op_b[W-1];
  assign w_b_exp  = op_b[W-2:M];
  assign w_b_frac = op_b[M-1:0];
  assign w_a_cls  = fp_classify(&w_a_exp, ~|w_a_exp, ~|w_a_frac, w_a_frac[M-1]);
  assign w_b_cls  = fp_classify(&w_b_exp, ~|w_b_exp, ~|w_b_frac, w_b_frac[M-1]);
  assign w_a_nan  = (w_a_cls == QNAN) || (w_a_cls == SNAN);
  assign w_b_nan  = (w_b_cls == QNAN) || (w_b_cls == SNAN);

  // Operand pairs resolved without the datapath (signs are post-negation).
  always_comb begin
    w_special      = 1'b1;
    w_spec_invalid = 1'b0;
    w_spec_result  = {W{1'b0}};
    if (w_a_nan || w_b_nan) begin
      w_spec_result  = QNAN_C;
      w_spec_invalid = (w_a_cls == SNAN) || (w_b_cls == SNAN);
    end else if ((w_a_cls == INF) && (w_b_cls == INF)) begin
      if (w_a_sign != w_b_sign) begin
        w_spec_result  = QNAN_C;
        w_spec_invalid = 1'b1;
      end else begin
        w_spec_result = {w_a_sign, {E{1'b1}}, {M{1'b0}}};
      end
    end else if (w_a_cls == INF) begin
      w_spec_result = {w_a_sign, {E{1'b1}}, {M{1'b0}}};
    end else if (w_b_cls == INF) begin
      w_spec_result = {w_b_sign, {E{1'b1}}, {M{1'b0}}};
    end else if ((w_a_cls == ZERO) && (w_b_cls == ZERO)) begin
      w_spec_result = {w_a_sign & w_b_sign, {(W-1){1'b0}}};
    end else if (w_a_cls == ZERO) begin
      w_spec_result = {w_b_sign, w_b_exp, w_b_frac};
    end else if (w_b_cls == ZERO) begin
      w_spec_result = {w_a_sign, w_a_exp, w_a_frac};
    end else begin
      w_special = 1'b0;
    end
  end

  logic          w_swap, w_l_sign;
  logic [E-1:0]  w_l_exp, w_s_exp, w_diff;
  logic [M-1:0]  w_l_frac, w_s_frac;
  logic [FW-1:0] w_b_aligned;

  assign w_swap   = {r_b_exp, r_b_frac} > {r_a_exp, r_a_frac};
  assign w_l_sign = w_swap ? r_b_sign : r_a_sign;
  assign w_l_exp  = w_swap ? r_b_exp  : r_a_exp;
  assign w_l_frac = w_swap ? r_b_frac : r_a_frac;
  assign w_s_exp  = w_swap ? r_a_exp  : r_b_exp;
  assign w_s_frac = w_swap ? r_a_frac : r_b_frac;
  assign w_diff   = w_l_exp - w_s_exp;

  fp_align_shifter #(.FW(FW), .SW(E)) u_align (
    .i_data  ({1'b1, w_s_frac, 3'b000}),
    .i_shamt (w_diff),
    .o_data  (w_b_aligned)
  );

  logic [FW:0]   w_sum, w_shl;
  logic [XW-1:0] w_exp_dec, w_exp_rnd;
  logic [M:0]    w_mant;
  logic [M+1:0]  w_mant_rnd;
  logic [M-1:0]  w_frac_rnd;
  logic          w_rnd_up, w_inexact;

  assign w_sum      = r_sub ? ({1'b0, r_mant_a} - {1'b0, r_mant_b})
                            : ({1'b0, r_mant_a} + {1'b0, r_mant_b});
  assign w_shl      = {r_mant[FW-1:0], 1'b0};
  assign w_exp_dec  = r_exp - EXP_ONE_C;
  // Round-to-nearest-even on the G,R,S tail of the normalised field.
  assign w_mant     = r_mant[FW-1:3];
  assign w_rnd_up   = r_mant[2] & (r_mant[1] | r_mant[0] | w_mant[0]);
  assign w_inexact  = r_mant[2] | r_mant[1] | r_mant[0];
  assign w_mant_rnd = {1'b0, w_mant} + {{(M+1){1'b0}}, w_rnd_up};
  assign w_exp_rnd  = w_mant_rnd[M+1] ? (r_exp + EXP_ONE_C) : r_exp;
  assign w_frac_rnd = w_mant_rnd[M+1] ? w_mant_rnd[M:1] : w_mant_rnd[M-1:0];

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= {W{1'b0}};
      r_flags     <= 4'b0000;
      r_a_sign    <= 1'b0;
      r_b_sign    <= 1'b0;
      r_a_exp     <= {E{1'b0}};
      r_b_exp     <= {E{1'b0}};
      r_a_frac    <= {M{1'b0}};
      r_b_frac    <= {M{1'b0}};
      r_sign      <= 1'b0;
      r_sub       <= 1'b0;
      r_exp       <= {XW{1'b0}};
      r_mant_a    <= {FW{1'b0}};
      r_mant_b    <= {FW{1'b0}};
      r_mant      <= {(FW+1){1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            if (w_special) begin
              r_result    <= w_spec_result;
              r_flags     <= {w_spec_invalid, 3'b000};
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_a_sign <= w_a_sign;
              r_a_exp  <= w_a_exp;
              r_a_frac <= w_a_frac;
              r_b_sign <= w_b_sign;
              r_b_exp  <= w_b_exp;
              r_b_frac <= w_b_frac;
              r_state  <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          r_mant_a <= {1'b1, w_l_frac, 3'b000};
          r_mant_b <= w_b_aligned;
          r_sign   <= w_l_sign;
          r_sub    <= r_a_sign ^ r_b_sign;
          r_exp    <= {2'b00, w_l_exp};
          r_state  <= S_ADDSUB;
        end
        S_ADDSUB: begin
          if (w_sum == {(FW+1){1'b0}}) begin
            r_result    <= {W{1'b0}};
            r_flags     <= 4'b0000;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_mant  <= w_sum;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_mant[FW]) begin
            r_mant  <= {1'b0, r_mant[FW:2], r_mant[1] | r_mant[0]};
            r_exp   <= r_exp + EXP_ONE_C;
            r_state <= S_ROUND;
          end else if (r_mant[FW-1]) begin
            r_state <= S_ROUND;
          end else if (w_exp_dec == {XW{1'b0}}) begin
            r_result    <= {r_sign, {(W-1){1'b0}}};
            r_flags     <= 4'b0011;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            // Leave NORM on the same cycle the hidden bit arrives.
            r_mant <= w_shl;
            r_exp  <= w_exp_dec;
            if (w_shl[FW-1]) begin
              r_state <= S_ROUND;
            end
          end
        end
        S_ROUND: begin
          if (w_exp_rnd >= EXP_MAX_C) begin
            r_result <= {r_sign, {E{1'b1}}, {M{1'b0}}};
            r_flags  <= 4'b0101;
          end else begin
            r_result <= {r_sign, w_exp_rnd[E-1:0], w_frac_rnd};
            r_flags  <= {3'b000, w_inexact};
          end
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Directed bench for fp_subtractor_seq: hand-computed vectors, latency,
// backpressure and reset-abort checks via immediate assertions.
module tb_fp_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op_a, op_b, result;
  logic [3:0]  flags;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  fp_subtractor_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  // Present an operand pair from a negedge; returns right after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_in_ready", {31'd0, in_ready}, 32'd1);
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
  endtask

  // Count negedges after the accept edge until out_valid shows (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov_after"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ir_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic [3:0] exp_f, input int exp_lat);
    int lat;
    send(a, b);
    wait_out(lat);
    check({tag, "_res"}, result, exp_r);
    check({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_f});
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    handoff(tag);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 32'h0000_0000;
    op_b      = 32'h0000_0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'h0000_0000);
    check("rst_flags", {28'd0, flags}, 32'd0);
    rst_n = 1'b1;

    run_op("3m1",       32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 5);
    run_op("1m2e-24",   32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF, 4'b0000, 5);
    run_op("2e24m1",    32'h4B80_0000, 32'h3F80_0000, 32'h4B7F_FFFF, 4'b0000, 5);
    run_op("tie_even",  32'h4B80_0000, 32'hBF80_0000, 32'h4B80_0000, 4'b0001, 5);
    run_op("tie_up",    32'h4B80_0001, 32'hBF80_0000, 32'h4B80_0002, 4'b0001, 5);
    run_op("carry",     32'h3FC0_0000, 32'hC020_0000, 32'h4080_0000, 4'b0000, 5);
    run_op("neg_add",   32'hC000_0000, 32'h4000_0000, 32'hC080_0000, 4'b0000, 5);
    run_op("inf_inf",   32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, 1);
    run_op("overflow",  32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4'b0101, 5);
    run_op("exact0",    32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 3);
    run_op("k23",       32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000, 4'b0000, 27);
    run_op("underflow", 32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 4'b0011, 4);
    run_op("qnan",      32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000, 1);
    run_op("snan",      32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1);
    run_op("negz",      32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0000, 1);
    run_op("posz",      32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, 1);
    run_op("m_neginf",  32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0000, 4'b0000, 1);
    run_op("denorm_a",  32'h0040_0000, 32'h3F80_0000, 32'hBF80_0000, 4'b0000, 1);

    // Backpressure: result must hold and fresh operands must be ignored.
    send(32'h4040_0000, 32'h3F80_0000);
    wait_out(lat);
    check("bp_first_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      op_a     = 32'h7F80_0000;
      op_b     = 32'h7F80_0000;
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_result", result, 32'h4000_0000);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    handoff("bp");
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("bp_single_handoff", 32'(seen), 32'd0);

    // Reset while the k=23 operation sits in NORM.
    send(32'h3F80_0001, 32'h3F80_0000);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstn_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstn_in_ready", {31'd0, in_ready}, 32'd1);
    check("rstn_result", result, 32'h0000_0000);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rstn_no_stale", 32'(seen), 32'd0);

    run_op("post_rst", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
